// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with valid/ready request, fixed-latency response
// pulse, RV32 load/store widths and misalignment / illegal-funct3 flagging.

module dmem_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);
    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module dmem_lsu #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH+1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o
);
    localparam int NUM_LANES = 4;
    localparam int CNT_W     = $clog2(LATENCY) + 1;
    localparam int AW        = ADDR_WIDTH + 2;

    typedef struct packed {
        logic          we;
        logic [2:0]    funct3;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    req_t                            req_q;
    logic                            accept, access, err;
    logic                            rsp_err_q;
    logic [31:0]                     rsp_rdata_q, word, shifted, load_data;
    logic [1:0]                      lane;
    logic [ADDR_WIDTH-1:0]           idx;
    logic [NUM_LANES-1:0]            be, lane_we;
    logic [NUM_LANES-1:0][7:0]       wdata_lanes, rd_lanes;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: if (req_valid_i) begin
                accept  = 1'b1;
                state_d = WAIT;
                cnt_d   = CNT_W'(LATENCY - 1);
            end
            WAIT: if (cnt_q == '0) begin
                access  = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || req_q.we) ? '0 : load_data;
            end else if (state_q == RESP) begin
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept)
            req_q <= '{we: req_we_i, funct3: req_funct3_i, addr: req_addr_i, wdata: req_wdata_i};
    end

    assign lane = req_q.addr[1:0];
    assign idx  = req_q.addr[AW-1:2];

    // funct3[2] (unsigned) only exists for loads
    always_comb begin
        case (req_q.funct3)
            3'b000:  err = 1'b0;
            3'b001:  err = lane[0];
            3'b010:  err = |lane;
            3'b100:  err = req_q.we;
            3'b101:  err = req_q.we | lane[0];
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        be          = '0;
        wdata_lanes = '0;
        case (req_q.funct3[1:0])
            2'b00: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{req_q.wdata[7:0]}};
            end
            2'b01: begin
                be          = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_q.wdata[15:0]}};
            end
            2'b10: begin
                be          = 4'b1111;
                wdata_lanes = req_q.wdata;
            end
            default: ;
        endcase
    end

    // a reset landing on the access edge drops the store
    assign lane_we = (access && req_q.we && !err && !rst_i) ? be : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
            .clk_i (clk_i),
            .we    (lane_we[i]),
            .idx   (idx),
            .wdata (wdata_lanes[i]),
            .rdata (rd_lanes[i])
        );
    end

    assign word    = rd_lanes;
    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        case (req_q.funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (LATENCY 1/3/4) checked against a
// byte-array reference model with directed and random load/store traffic.

module tb_dmem_lsu;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [NDUT];
    logic        req_we    [NDUT];
    logic [2:0]  req_f3    [NDUT];
    logic [11:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic        req_ready [NDUT];
    logic        rsp_valid [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];

    bit [7:0] mm [NDUT][4096];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_lsu #(.ADDR_WIDTH(10), .LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (req_ready[g]),
            .req_we_i     (req_we[g]),
            .req_funct3_i (req_f3[g]),
            .req_addr_i   (req_addr[g]),
            .req_wdata_i  (req_wdata[g]),
            .rsp_valid_o  (rsp_valid[g]),
            .rsp_rdata_o  (rsp_rdata[g]),
            .rsp_err_o    (rsp_err[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: byte array, access size from funct3, plain alignment arithmetic
    function automatic void model_op(input int k, input bit we, input bit [2:0] f3, input int addr,
                                     input logic [31:0] wd, output logic [31:0] rd, output bit err);
        int size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        err  = (f3[1:0] == 2'd3) || (f3 == 3'b110) || (we && f3[2]) || (addr % size != 0);
        rd   = '0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mm[k][addr + i] = wd[8*i +: 8];
            return;
        end
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(mm[k][addr + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
    endfunction

    task automatic txn(input int k, input bit we, input bit [2:0] f3, input int addr,
                       input logic [31:0] wd, input string tag,
                       output logic [31:0] rd, output bit err);
        int c;
        logic [31:0] erd;
        bit eerr;
        @(negedge clk);
        c = 0;
        while (!req_ready[k] && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "/ready"}, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_we[k] = we; req_f3[k] = f3;
        req_addr[k] = 12'(addr); req_wdata[k] = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        chk({tag, "/busy"}, 32'(req_ready[k]), 32'd0);
        for (c = 0; c <= lat_of(k) + 3; c++) begin
            if (rsp_valid[k]) break;
            @(negedge clk);
        end
        chk({tag, "/lat"}, 32'(c), 32'(lat_of(k)));
        rd  = rsp_rdata[k];
        err = rsp_err[k];
        model_op(k, we, f3, addr, wd, erd, eerr);
        chk({tag, "/rdata"}, rd, erd);
        chk({tag, "/err"}, 32'(err), 32'(eerr));
        @(negedge clk);
        chk({tag, "/pulse"}, 32'(rsp_valid[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, ref_word, erd;
        bit er, eer;
        int low, pulses, c;
        logic [31:0] prd;

        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_f3[k] = '0;
            req_addr[k] = '0; req_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst%0d/ready", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("rst%0d/valid", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("rst%0d/rdata", k), rsp_rdata[k], 32'd0);
            chk($sformatf("rst%0d/err", k), 32'(rsp_err[k]), 32'd0);
        end
        rst = 1'b0;

        // preload words 0..31 of each instance, plus the top word
        for (int k = 0; k < NDUT; k++) begin
            for (int w = 0; w < 32; w++) txn(k, 1, 3'b010, 4 * w, $urandom, "init", rd, er);
            txn(k, 1, 3'b010, 12'hFFC, $urandom, "top_sw", rd, er);
            txn(k, 0, 3'b010, 12'hFFC, 0, "top_lw", rd, er);
            txn(k, 0, 3'b001, 12'hFFE, 0, "top_lh", rd, er);
        end

        txn(0, 1, 3'b010, 'h10, 32'hDEADBEEF, "t1_sw", rd, er);
        txn(0, 0, 3'b010, 'h10, 0, "t1_lw", rd, er);
        chk("t1_lw_const", rd, 32'hDEADBEEF);
        chk("t1_err_const", 32'(er), 32'd0);

        txn(0, 1, 3'b010, 'h20, 32'h11223344, "t2_sw", rd, er);
        txn(0, 1, 3'b000, 'h22, 32'h000000AA, "t2_sb", rd, er);
        txn(0, 0, 3'b010, 'h20, 0, "t2_lw", rd, er);
        chk("t2_lw_const", rd, 32'h11AA3344);
        txn(0, 0, 3'b000, 'h22, 0, "t2_lb", rd, er);
        chk("t2_lb_const", rd, 32'hFFFFFFAA);
        txn(0, 0, 3'b100, 'h22, 0, "t2_lbu", rd, er);
        chk("t2_lbu_const", rd, 32'h000000AA);

        txn(0, 1, 3'b010, 'h30, 32'h0, "t3_sw", rd, er);
        txn(0, 1, 3'b001, 'h32, 32'h00008001, "t3_sh", rd, er);
        txn(0, 0, 3'b001, 'h32, 0, "t3_lh", rd, er);
        chk("t3_lh_const", rd, 32'hFFFF8001);
        txn(0, 0, 3'b101, 'h32, 0, "t3_lhu", rd, er);
        chk("t3_lhu_const", rd, 32'h00008001);
        txn(0, 0, 3'b010, 'h30, 0, "t3_lw", rd, er);
        chk("t3_lw_const", rd, 32'h80010000);

        txn(0, 0, 3'b010, 'h40, 0, "t4_pre", ref_word, er);
        txn(0, 0, 3'b010, 'h41, 0, "t4_lw_mis", rd, er);
        chk("t4_lw_mis_err", 32'(er), 32'd1);
        chk("t4_lw_mis_rd", rd, 32'd0);
        txn(0, 1, 3'b001, 'h43, 32'h0000FFFF, "t4_sh_mis", rd, er);
        chk("t4_sh_mis_err", 32'(er), 32'd1);
        txn(0, 0, 3'b011, 'h40, 0, "t4_f3_011", rd, er);
        chk("t4_f3_err", 32'(er), 32'd1);
        txn(0, 1, 3'b100, 'h40, 32'h12345678, "t4_sbu_ill", rd, er);
        chk("t4_st_ill_err", 32'(er), 32'd1);
        txn(0, 0, 3'b010, 'h40, 0, "t4_post", rd, er);
        chk("t4_unchanged", rd, ref_word);

        // LATENCY=4 with req_valid held high back to back
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_f3[2] = 3'b010;
        req_addr[2] = 12'h010; req_wdata[2] = '0;
        model_op(2, 0, 3'b010, 'h10, 0, erd, eer);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("t5_%0d/ready", r), 32'(req_ready[2]), 32'd1);
            @(posedge clk);
            low = 0; pulses = 0; prd = '0;
            for (c = 0; c < 20; c++) begin
                @(negedge clk);
                if (req_ready[2]) break;
                low++;
                if (rsp_valid[2]) begin
                    pulses++;
                    prd = rsp_rdata[2];
                end
            end
            chk($sformatf("t5_%0d/low", r), 32'(low), 32'd5);
            chk($sformatf("t5_%0d/pulses", r), 32'(pulses), 32'd1);
            chk($sformatf("t5_%0d/rdata", r), prd, erd);
        end
        req_valid[2] = 1'b0;

        // reset one cycle after a store accept (LATENCY=3)
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_f3[1] = 3'b000;
        req_addr[1] = 12'h022; req_wdata[1] = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        chk("t6_accepted", 32'(req_ready[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_ready", 32'(req_ready[1]), 32'd1);
        chk("t6_rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("t6_rst_rdata", rsp_rdata[1], 32'd0);
        chk("t6_rst_err", 32'(rsp_err[1]), 32'd0);
        rst = 1'b0;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_f3[1] = 3'b010; req_addr[1] = 12'h020;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("t6_next_accept", 32'(req_ready[1]), 32'd0);
        for (c = 0; c < 10; c++) begin
            if (rsp_valid[1]) break;
            @(negedge clk);
        end
        model_op(1, 0, 3'b010, 'h20, 0, erd, eer);
        chk("t6_lat", 32'(c), 32'd3);
        chk("t6_no_write", rsp_rdata[1], erd);

        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 30; n++)
                txn(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 127)), $urandom, $sformatf("rnd%0d_%0d", k, n), rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
